// File: rtl/popcount_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : popcount_sequencer
// Description : Counts the set bits of a DATA_W-bit word by stepping one
//               4-input ones-counter across the word, one nibble per enabled
//               clock, with valid/ready handshakes on input and output.
//               Optional build macro: POPCOUNT_EARLY_EXIT_EN (finish as soon
//               as the remaining bits are all zero).
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_sequencer #(
  parameter int DATA_W = 32,  // multiple of 4, at least 4
  parameter int CNT_W  = 6    // at least clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int N     = DATA_W / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [4:0]        slice_onehot;
  logic [2:0]        slice_bin;
  logic [CNT_W-1:0]  acc_sum;
  logic [DATA_W-1:0] shift_nxt;
  logic              run_last;
  logic              in_zero;
  logic              in_fire;
  logic              out_fire;

  // Handshakes are purely combinational from state; ena gates both sides.
  assign in_ready  = ena & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = ena & (state_q == DONE);
  assign busy      = (state_q == RUN) | (state_q == DONE);
  assign out_count = count_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Shared 4-input ones-counter: one-hot result, bit k set means k ones.
  always_comb begin
    slice_onehot = 5'b00000;
    case (shift_q[3:0])
      4'h0:                               slice_onehot = 5'b00001;
      4'h1, 4'h2, 4'h4, 4'h8:             slice_onehot = 5'b00010;
      4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC: slice_onehot = 5'b00100;
      4'h7, 4'hB, 4'hD, 4'hE:             slice_onehot = 5'b01000;
      default:                            slice_onehot = 5'b10000;
    endcase
  end

  // One-hot to binary: 1->001, 2->010, 3->011, 4->100.
  assign slice_bin = {slice_onehot[4],
                      slice_onehot[3] | slice_onehot[2],
                      slice_onehot[3] | slice_onehot[1]};

  assign acc_sum   = acc_q + CNT_W'(slice_bin);
  assign shift_nxt = shift_q >> 4;

`ifdef POPCOUNT_EARLY_EXIT_EN
  // Stop once nothing is left to count; a zero word completes at accept.
  assign run_last = (idx_q == LAST_IDX) || (shift_nxt == '0);
  assign in_zero  = (in_data == '0);
`else
  assign run_last = (idx_q == LAST_IDX);
  assign in_zero  = 1'b0;
`endif

  // Next-state and datapath updates; an in transfer in DONE implies an out
  // transfer on the same edge, which gives the back-to-back path for free.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (state_q == RUN) begin
      acc_d   = acc_sum;
      shift_d = shift_nxt;
      idx_d   = idx_q + 1'b1;
      if (run_last) begin
        state_d = DONE;
        count_d = acc_sum;
      end
    end else if (in_fire) begin
      shift_d = in_data;
      acc_d   = '0;
      idx_d   = '0;
      if (in_zero) begin
        state_d = DONE;
        count_d = '0;
      end else begin
        state_d = RUN;
      end
    end else if (out_fire) begin
      state_d = IDLE;
    end
  end

  // State register; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Datapath registers; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (ena) begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_popcount_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_sequencer
// Description : Scoreboard bench for popcount_sequencer (DATA_W=32, CNT_W=6).
//               Directed scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int N      = DATA_W / 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  popcount_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected result: count, enabled-edge stamp after accept, latency in enabled edges.
  typedef struct {
    int cnt;
    int en0;
    int lat;
  } exp_t;
  exp_t q[$];
  int   en_cnt = 0;
  bit   armed  = 1'b0;

  function automatic int ref_count(input logic [DATA_W-1:0] w);
    int c = 0;
    for (int i = 0; i < DATA_W; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic int ref_lat(input logic [DATA_W-1:0] w);
`ifdef POPCOUNT_EARLY_EXIT_EN
    if (w == '0) return 0;
    for (int i = N - 1; i >= 0; i--)
      if (((w >> (4 * i)) & 32'hF) != 0) return i + 1;
`endif
    return N;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: checks outputs against the model, then applies the upcoming edge's events.
  always @(negedge clk) begin
    bit ph;
    if (armed) begin
      ph = (q.size() > 0) && ((en_cnt - q[0].en0) >= q[0].lat);
      check("busy", 32'(busy), 32'(q.size() > 0));
      check("out_valid", 32'(out_valid), 32'(ena && ph));
      check("in_ready", 32'(in_ready), 32'(ena && ((q.size() == 0) || (ph && out_ready))));
      if (out_valid && ph) check("out_count", 32'(out_count), 32'(q[0].cnt));
    end
    if (reset) begin
      q.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        e.cnt = ref_count(in_data);
        e.en0 = en_cnt + 1;
        e.lat = ref_lat(in_data);
        q.push_back(e);
      end
      if (ena) en_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word until accepted, bounded.
  task automatic send(input logic [DATA_W-1:0] w);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready && !reset;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %h got not-accepted expected accepted", w);
    end
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    send(32'hFFFF_FFFF); idle(12);
    send(32'h0000_0001); send(32'h8000_0000); idle(12);

    out_ready = 1'b0;
    send(32'hA5A5_0F0F); idle(13);
    out_ready = 1'b1;
    send(32'h0000_0003); idle(12);

    send(32'h1234_5678); idle(3);
    ena = 1'b0; idle(3);
    ena = 1'b1; idle(12);

    send(32'hDEAD_BEEF); idle(4);
    reset = 1'b1; idle(1);
    reset = 1'b0;
    send(32'h0000_000F); idle(12);

    send(32'h0000_0010); idle(12);
    send(32'h0000_0000); idle(12);

    for (int c = 0; c < 2500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       in_data = '0;
        1:       in_data = '1;
        2:       in_data = 32'h1 << $urandom_range(0, 31);
        default: in_data = $urandom;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      ena       = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end

    reset = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    idle(20);
    check("drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got time-limit expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/popcount_sequencer.md
Name: popcount_sequencer

Overview:
- Time-multiplexes one 4-input ones-counter stage over a wide input word, 4 bits per cycle, and accumulates the total set-bit count.
- Sits between a producer and a consumer. Uses valid/ready handshakes on both sides.
- Lets the team count ones in DATA_W-bit words without replicating the combinational 4-bit counter.
- The 4-bit stage is internal and has a one-hot count output (bit k set means k ones, k=0..4). The sequencer decodes it to binary before accumulating.

Parameters:
- DATA_W, default 32: input word width. Must be a multiple of 4 and at least 4. N = DATA_W/4 slices.
- CNT_W, default 6: count width. Must satisfy CNT_W >= clog2(DATA_W+1).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- ena, input, 1: global enable. When low, the block freezes.
- in_valid, input, 1: producer has a word.
- in_ready, output, 1: block can accept a word.
- in_data, input, DATA_W: word to count.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result.
- out_count, output, CNT_W: number of ones in the accepted word.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: state=IDLE, shift register=0, slice index=0, accumulator=0, out_count=0, out_valid=0, busy=0.
- Reset has priority over everything. Reset mid-RUN or mid-DONE discards the word with no output.
- FSM states: IDLE, RUN, DONE. Every state register updates only on edges where ena=1.
- Handshake signals (combinational):
  - in_ready = ena & ((state==IDLE) | (state==DONE & out_ready)).
  - out_valid = ena & (state==DONE).
  - A transfer happens only on an edge where valid & ready are both high.
- IDLE, on accept: load shift register with in_data, accumulator=0, index=0, go to RUN.
- RUN, on each enabled edge:
  - accumulator += binary decode of onehot(shift[3:0]).
  - shift register >>= 4; index += 1.
  - When index==N-1 on this edge, go to DONE and load out_count with the final sum.
- DONE:
  - out_count and out_valid held stable until out_ready is high with ena high.
  - On out transfer with no simultaneous in transfer: go to IDLE.
  - On out transfer with a simultaneous in transfer (back-to-back): load the new word and go directly to RUN.
- out_count is registered and is not cleared on leaving DONE. It is only meaningful while out_valid=1.
- Latency, with ena held high: accept at edge k gives out_valid=1 after edge k+N. Each cycle with ena=0 adds exactly one cycle.
- Width: the accumulator is CNT_W bits and cannot overflow, because the maximum count is DATA_W.
- in_valid while busy: ignored (no transfer, producer holds). in_data is sampled only at accept.
- Simultaneous reset and handshake: reset wins and no transfer is recorded.

Optional Feature:
- Macro: POPCOUNT_EARLY_EXIT_EN.
- With the macro, RUN goes to DONE on any edge where the post-shift register value is 0, even if index < N-1.
- With the macro, accepting in_data==0 goes directly to DONE with out_count=0, so out_valid is high after the accept edge.
- Without the macro, latency is always N cycles and the zero checks are not present in the netlist.

Test Plan (DATA_W=32, CNT_W=6, ena=1 unless stated):
- Accept 0xFFFFFFFF at edge k -> out_valid=1 after edge k+8, out_count=32; in_ready=0 during RUN.
- Accept 0x00000001, then 0x80000000 -> out_count=1 each. Confirms first and last slice are counted; latency 8 each.
- Accept 0xA5A50F0F with out_ready held low 5 cycles after DONE -> out_count=16 stable and out_valid=1 throughout. Then assert out_ready with in_valid=1 and data 0x00000003 -> same-edge back-to-back accept, next out_count=2.
- Deassert ena for 3 cycles mid-RUN on 0x12345678 -> out_count=13, out_valid delayed by exactly 3 cycles. While ena=0, in_ready=0 and out_valid=0.
- Assert reset for one cycle at RUN index 4 -> out_valid=0, busy=0, in_ready=1. Next word 0x0000000F gives out_count=4.
- With POPCOUNT_EARLY_EXIT_EN:
  - 0x00000010 -> DONE after 2 RUN edges, out_count=1.
  - 0x00000000 -> out_valid high after the accept edge, out_count=0.
